multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
- Parametrised iterative signed multiply/divide unit for the execute stage of the 5-stage pipeline.
- Successor to the fixed 32-bit multdiv:
  - generic WIDTH
  - explicit busy and flush
  - back-to-back issue from DONE
  - defined divide-overflow handling
  - optional early termination on multiply
- The pipeline stalls on busy and consumes data_result/data_exception when data_resultRDY pulses.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
clock  input  1  master clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
data_operandA  input  WIDTH  signed multiplicand / dividend, sampled only on the accepting edge
data_operandB  input  WIDTH  signed multiplier / divisor, sampled only on the accepting edge
ctrl_MULT  input  1  start multiply (level, sampled when unit can accept)
ctrl_DIV  input  1  start divide (level, sampled when unit can accept)
flush  input  1  abort the in-flight operation (branch/jump squash)
data_result  output  WIDTH  signed result (low WIDTH bits of product, or truncated quotient)
data_exception  output  1  overflow / divide-by-zero flag for the completed operation
data_resultRDY  output  1  one-cycle completion pulse
busy  output  1  high while an operation is in flight (state RUN)

Behaviour:
- States:
  - IDLE: no operation.
  - RUN: iterating.
  - DONE: result valid; data_resultRDY=1 for exactly this one cycle.
- Reset:
  - state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Internal accumulators and counter cleared.
- Accept:
  - In IDLE or DONE, an edge with ctrl_MULT|ctrl_DIV latches the operands and enters RUN, counter=0.
  - Operands are stored as magnitudes plus a result-sign bit (signA XOR signB).
  - ctrl_MULT and ctrl_DIV together: multiply wins.
  - Start requests in RUN are ignored.
  - Accepting from DONE gives back-to-back issue; data_resultRDY still pulses only in the DONE cycle.
- Multiply:
  - Shift-add, one multiplier bit per RUN edge, LSB first, into a 2*WIDTH-bit accumulator.
  - Leaves RUN when counter reaches WIDTH.
  - Latency: accepting edge k → DONE after edge k+WIDTH.
- Divide:
  - Restoring division, one quotient bit per RUN edge; latency WIDTH, same timing as multiply.
  - Quotient truncates toward zero; remainder is discarded.
- Divide by zero: detected at the accepting edge; the unit still enters RUN and goes to DONE on the next edge (latency 1) with data_result=0, data_exception=1.
- Result write:
  - On the edge entering DONE, data_result gets the sign-corrected value and data_exception its flag.
  - Both hold until the next completion or reset.
- Multiply overflow: exception=1 when the signed 2*WIDTH product is not the sign extension of its low WIDTH bits; data_result = low WIDTH bits.
- Divide overflow: MIN_INT / -1 gives data_result=MIN_INT (1 followed by zeros), data_exception=1.
- Flush:
  - An edge with flush=1 forces IDLE from any state; data_resultRDY=0 next cycle; data_result and data_exception unchanged.
  - Flush overrides a simultaneous start.
- reset overrides flush and start.
- busy = (state==RUN), combinational from state.

Optional Feature:
MULTDIV_EARLY_TERM_EN
- Defined: multiply leaves RUN on the first step edge after which the remaining multiplier bits are all zero, or when counter reaches WIDTH.
  - Latency L = max(1, bit-length of |operandB|).
  - The result is identical to the full-length run.
  - Divide is unaffected.
- Undefined: multiply latency is always WIDTH.

Test Plan:
- WIDTH=32, macro undefined.
  - Multiply 7 × -3, start at edge k → RDY high only in the cycle after edge k+32; result 0xFFFFFFEB, exception 0; busy high for 32 cycles.
  - Multiply 0x00010000 × 0x00010000 → result 0x00000000, exception 1.
  - Divide -17 / 5 → result 0xFFFFFFFD (-3), exception 0.
  - Divide 9 / 0 → RDY after edge k+1, result 0, exception 1.
  - Divide 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1.
  - Start a multiply, assert flush at RUN cycle 10 → busy low the next cycle; RDY never pulses; prior data_result held. A divide 100/7 issued immediately after → result 14.
  - With ctrl_MULT held high: 5×6 completes, and the DONE-cycle start of 2×2 is accepted. RDY pulses at k+32 (result 30) and k+65 (result 4); no idle cycle between the runs.
- WIDTH=8: multiply 0x40 × 0x02 → result 0x80, exception 1; -8 × 16 → result 0x80, exception 0.
- Macro defined, WIDTH=32:
  - Multiply 100 × 3 → RDY after edge k+2, result 300.
  - Multiply 5 × 0 → RDY after edge k+1, result 0.
  - Multiply -1 × -1 → RDY after edge k+1, result 1.

Source files
------------

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit with flush and back-to-back issue.
// Optional MULTDIV_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are all zero.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             flush,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    state_t           r_state, w_state_next;
    logic             r_is_div, r_sign, r_dz;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [WIDTH-1:0] r_b, w_b_shift;
    logic [W2-1:0]    r_a, r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;

    logic             w_start, w_accept, w_last_cnt, w_mul_last, w_finish;
    logic [W2-1:0]    w_acc_mul, w_acc_div, w_prod;
    logic [WIDTH:0]   w_rem_sh, w_diff;
    logic [WIDTH-1:0] w_quo, w_quo_s, w_res_next;
    logic             w_exc_next;

    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        f_abs = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // True when a 2W-bit signed product does not fit in W signed bits
    function automatic logic f_not_sext(input logic [W2-1:0] p);
        f_not_sext = !((&p[W2-1:WIDTH-1]) || !(|p[W2-1:WIDTH-1]));
    endfunction

    assign w_start    = ctrl_MULT | ctrl_DIV;
    assign w_accept   = (r_state != S_RUN) && w_start && !flush;
    assign w_cnt_next = r_cnt + CW'(1);
    assign w_last_cnt = (w_cnt_next == CW'(WIDTH));
    assign w_b_shift  = r_b >> 1;

    // Datapath step, finish detection and sign-corrected result
    always_comb begin
        w_acc_mul = r_acc + (r_b[0] ? r_a : {W2{1'b0}});
        w_rem_sh  = {r_acc[W2-1:WIDTH], r_acc[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_b};
        if (w_diff[WIDTH]) begin
            w_acc_div = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
            w_acc_div = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
`ifdef MULTDIV_EARLY_TERM_EN
        w_mul_last = w_last_cnt || (w_b_shift == {WIDTH{1'b0}});
`else
        w_mul_last = w_last_cnt;
`endif
        w_finish = r_dz || (r_is_div ? w_last_cnt : w_mul_last);
        w_prod   = r_sign ? (~w_acc_mul + W2'(1)) : w_acc_mul;
        w_quo    = w_acc_div[WIDTH-1:0];
        w_quo_s  = r_sign ? (~w_quo + WIDTH'(1)) : w_quo;
        if (r_dz) begin
            w_res_next = {WIDTH{1'b0}};
            w_exc_next = 1'b1;
        end else if (r_is_div) begin
            // A positive quotient with the top bit set only arises from MIN_INT / -1
            w_res_next = w_quo_s;
            w_exc_next = !r_sign && w_quo[WIDTH-1];
        end else begin
            w_res_next = w_prod[WIDTH-1:0];
            w_exc_next = f_not_sext(w_prod);
        end
    end

    // Next-state logic; flush dominates any start request
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: w_state_next = w_start ? S_RUN : S_IDLE;
                S_RUN:          w_state_next = w_finish ? S_DONE : S_RUN;
                default:        w_state_next = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture, iteration and result write
    always_ff @(posedge clock) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_sign   <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            r_a      <= {W2{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_acc    <= {W2{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_exc    <= 1'b0;
        end else if (w_accept) begin
            r_is_div <= !ctrl_MULT;
            r_sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dz     <= !ctrl_MULT && (data_operandB == {WIDTH{1'b0}});
            r_cnt    <= {CW{1'b0}};
            r_a      <= W2'(f_abs(data_operandA));
            r_b      <= f_abs(data_operandB);
            r_acc    <= ctrl_MULT ? {W2{1'b0}} : W2'(f_abs(data_operandA));
        end else if (!flush && r_state == S_RUN) begin
            r_cnt <= w_cnt_next;
            if (r_is_div) begin
                r_acc <= w_acc_div;
            end else begin
                r_acc <= w_acc_mul;
                r_a   <= r_a << 1;
                r_b   <= w_b_shift;
            end
            if (w_finish) begin
                r_result <= w_res_next;
                r_exc    <= w_exc_next;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == S_DONE);
    assign busy           = (r_state == S_RUN);
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed, table-driven bench for multdiv_iter (WIDTH=32 and WIDTH=8 instances).
module tb_multdiv_iter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [31:0] a32, b32;
    logic        m32, d32, f32;
    logic [31:0] r32;
    logic        e32, rdy32, busy32;
    logic [7:0]  a8, b8;
    logic        m8, d8, f8;
    logic [7:0]  r8;
    logic        e8, rdy8, busy8;

    multdiv_iter #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .data_operandA(a32), .data_operandB(b32),
        .ctrl_MULT(m32), .ctrl_DIV(d32), .flush(f32), .data_result(r32),
        .data_exception(e32), .data_resultRDY(rdy32), .busy(busy32));

    multdiv_iter #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .data_operandA(a8), .data_operandB(b8),
        .ctrl_MULT(m8), .ctrl_DIV(d8), .flush(f8), .data_result(r8),
        .data_exception(e8), .data_resultRDY(rdy8), .busy(busy8));

    typedef struct {
        bit          mul;
        bit          both;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
        int          lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(bit mul, bit both, logic [31:0] a, logic [31:0] b,
                                logic [31:0] res, bit exc, int lat, int lat_et);
        vec_t v;
        v.mul = mul; v.both = both; v.a = a; v.b = b; v.res = res; v.exc = exc;
`ifdef MULTDIV_EARLY_TERM_EN
        v.lat = lat_et;
`else
        v.lat = lat;
`endif
        return v;
    endfunction

    task automatic start32(input bit mul, input bit both, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        a32 = a; b32 = b; m32 = mul | both; d32 = !mul | both;
        @(posedge clock);
    endtask

    // Called just after an accepting edge; n = edges until RDY seen
    task automatic wait32(input bit keep, output int n, output int bcnt);
        bit seen;
        seen = 1'b0; n = 0; bcnt = 0;
        while (!seen && n < 200) begin
            @(negedge clock);
            if (!keep) begin m32 = 1'b0; d32 = 1'b0; end
            if (rdy32) seen = 1'b1;
            else begin
                if (busy32) bcnt++;
                @(posedge clock);
                n++;
            end
        end
        chk("rdy_timeout32", {63'd0, seen}, 64'd1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res, input bit exc);
        int n;
        @(negedge clock);
        a8 = a; b8 = b; m8 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        m8 = 1'b0;
        n = 0;
        while (!rdy8 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("rdy_timeout8", {63'd0, rdy8}, 64'd1);
        chk("res8", {56'd0, r8}, {56'd0, res});
        chk("exc8", {63'd0, e8}, {63'd0, exc});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, bc, n1, b1, n2, b2, l1, l2;
        bit pulsed;
        vecs[0]  = mk(1, 0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0, 32, 2);
        vecs[1]  = mk(1, 0, 32'h00010000,   32'h00010000, 32'h00000000, 1, 32, 17);
        vecs[2]  = mk(0, 0, 32'hFFFFFFEF,   32'd5,        32'hFFFFFFFD, 0, 32, 32);
        vecs[3]  = mk(0, 0, 32'd9,          32'd0,        32'd0,        1, 1, 1);
        vecs[4]  = mk(0, 0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, 32, 32);
        vecs[5]  = mk(1, 0, 32'd100,        32'd3,        32'd300,      0, 32, 2);
        vecs[6]  = mk(1, 0, 32'd5,          32'd0,        32'd0,        0, 32, 1);
        vecs[7]  = mk(1, 0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        0, 32, 1);
        vecs[8]  = mk(0, 0, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 0, 32, 32);
        vecs[9]  = mk(1, 0, 32'h80000000,   32'd1,        32'h80000000, 0, 32, 1);
        vecs[10] = mk(1, 0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1, 32, 1);
        vecs[11] = mk(1, 1, 32'd12,         32'd4,        32'd48,       0, 32, 3);
        vecs[12] = mk(0, 0, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       0, 32, 32);

        reset = 1'b1;
        a32 = '0; b32 = '0; m32 = 1'b0; d32 = 1'b0; f32 = 1'b0;
        a8 = '0; b8 = '0; m8 = 1'b0; d8 = 1'b0; f8 = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_res32", {32'd0, r32}, 64'd0);
        chk("rst_exc32", {63'd0, e32}, 64'd0);
        chk("rst_rdy32", {63'd0, rdy32}, 64'd0);
        chk("rst_busy32", {63'd0, busy32}, 64'd0);
        chk("rst_res8", {56'd0, r8}, 64'd0);
        chk("rst_busy8", {63'd0, busy8}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            start32(vecs[i].mul, vecs[i].both, vecs[i].a, vecs[i].b);
            wait32(1'b0, n, bc);
            chk($sformatf("res[%0d]", i), {32'd0, r32}, {32'd0, vecs[i].res});
            chk($sformatf("exc[%0d]", i), {63'd0, e32}, {63'd0, vecs[i].exc});
            chk($sformatf("lat[%0d]", i), 64'(n), 64'(vecs[i].lat));
            chk($sformatf("busy_cycles[%0d]", i), 64'(bc), 64'(vecs[i].lat));
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("rdy_pulse[%0d]", i), {63'd0, rdy32}, 64'd0);
            chk($sformatf("res_hold[%0d]", i), {32'd0, r32}, {32'd0, vecs[i].res});
        end

        // Flush in the 10th RUN cycle of a long multiply, then issue a divide at once
        start32(1'b1, 1'b0, 32'd5, 32'h40000000);
        pulsed = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            m32 = 1'b0; d32 = 1'b0;
            if (rdy32) pulsed = 1'b1;
            if (c == 10) f32 = 1'b1;
            else @(posedge clock);
        end
        @(posedge clock);
        @(negedge clock);
        f32 = 1'b0;
        chk("flush_busy", {63'd0, busy32}, 64'd0);
        chk("flush_rdy", {63'd0, rdy32 | pulsed}, 64'd0);
        chk("flush_res_hold", {32'd0, r32}, {32'd0, vecs[NV-1].res});
        chk("flush_exc_hold", {63'd0, e32}, {63'd0, vecs[NV-1].exc});
        a32 = 32'd100; b32 = 32'd7; d32 = 1'b1;
        @(posedge clock);
        wait32(1'b0, n, bc);
        chk("post_flush_div", {32'd0, r32}, 64'd14);
        chk("post_flush_lat", 64'(n), 64'd32);

        // Back-to-back with ctrl_MULT held through the DONE cycle
`ifdef MULTDIV_EARLY_TERM_EN
        l1 = 3; l2 = 2;
`else
        l1 = 32; l2 = 32;
`endif
        @(posedge clock);
        start32(1'b1, 1'b0, 32'd5, 32'd6);
        wait32(1'b1, n1, b1);
        chk("b2b_res1", {32'd0, r32}, 64'd30);
        chk("b2b_lat1", 64'(n1), 64'(l1));
        a32 = 32'd2; b32 = 32'd2;
        @(posedge clock);
        wait32(1'b0, n2, b2);
        chk("b2b_res2", {32'd0, r32}, 64'd4);
        chk("b2b_total", 64'(n1 + 1 + n2), 64'(l1 + 1 + l2));
        chk("b2b_no_idle", 64'(b2), 64'(l2));

        op8(8'h40, 8'h02, 8'h80, 1'b1);
        op8(8'hF8, 8'h10, 8'h80, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
